// File: rtl/alu_pkg.sv
// ALU operation encoding shared by decode, the ID/EX register and the ALU.
// No logic; types only.
// No flow control.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD_OP  = 4'd0,
        SUB_OP  = 4'd1,
        AND_OP  = 4'd2,
        OR_OP   = 4'd3,
        XOR_OP  = 4'd4,
        SLL_OP  = 4'd5,
        SRL_OP  = 4'd6,
        SRA_OP  = 4'd7,
        SLT_OP  = 4'd8,
        SLTU_OP = 4'd9
    } alu_op_e;

endpackage

// File: rtl/pipeline_pkg.sv
// Types for the decode->execute register: forwarding selector and latched fields.
// No logic; types only.
// No flow control.
package pipeline_pkg;

    localparam int unsigned PIPE_DATA_WIDTH     = 32;
    localparam int unsigned PIPE_REG_ADDR_WIDTH = 5;

    // Which source an operand came from after hazard resolution.
    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // Everything the ID/EX register keeps for one instruction.
    typedef struct packed {
        logic                             valid;
        alu_pkg::alu_op_e                 op;
        logic [PIPE_REG_ADDR_WIDTH-1:0]   rs1_addr;
        logic [PIPE_REG_ADDR_WIDTH-1:0]   rs2_addr;
        logic [PIPE_DATA_WIDTH-1:0]       rs1_data;
        logic [PIPE_DATA_WIDTH-1:0]       rs2_data;
        logic [PIPE_DATA_WIDTH-1:0]       imm;
        logic                             use_imm;
        logic [PIPE_REG_ADDR_WIDTH-1:0]   rd_addr;
        logic                             rd_we;
        logic                             is_load;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: picks EX/MEM result, MEM/WB result or register-file data for one source.
// Latency: purely combinational.
// No flow control; follows its inputs every cycle.
module fwd_mux
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
    input  logic [DATA_WIDTH-1:0]     i_rf_data,
    input  logic [REG_ADDR_WIDTH-1:0] i_exmem_rd_addr,
    input  logic                      i_exmem_rd_we,
    input  logic [DATA_WIDTH-1:0]     i_exmem_result,
    input  logic [REG_ADDR_WIDTH-1:0] i_memwb_rd_addr,
    input  logic                      i_memwb_rd_we,
    input  logic [DATA_WIDTH-1:0]     i_memwb_result,
    output logic [DATA_WIDTH-1:0]     o_value,
    output fwd_sel_e                  o_sel
);

    // Youngest producer wins; register 0 is never a forwarding target.
    always_comb begin
        o_sel = FWD_NONE;
        if (i_rs_addr != '0) begin
            if (i_exmem_rd_we && (i_exmem_rd_addr == i_rs_addr)) begin
                o_sel = FWD_EXMEM;
            end else if (i_memwb_rd_we && (i_memwb_rd_addr == i_rs_addr)) begin
                o_sel = FWD_MEMWB;
            end
        end
    end

    // Data select; x0 reads as zero even if the register file returned garbage.
    always_comb begin
        case (o_sel)
            FWD_EXMEM: o_value = i_exmem_result;
            FWD_MEMWB: o_value = i_memwb_result;
            default:   o_value = (i_rs_addr == '0) ? '0 : i_rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with operand forwarding and load-use bubble insertion.
// Latency: 1 cycle decode->ALU operands; forwarding applied combinationally on the outputs.
// Backpressure: i_stall holds all state; o_load_use_stall tells decode to hold its instruction.
module id_ex_stage
    import alu_pkg::*;
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = PIPE_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = PIPE_REG_ADDR_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  alu_op_e                   i_op,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr,
    input  logic [DATA_WIDTH-1:0]     i_rs1_data,
    input  logic [DATA_WIDTH-1:0]     i_rs2_data,
    input  logic [DATA_WIDTH-1:0]     i_imm,
    input  logic                      i_use_imm,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                      i_rd_we,
    input  logic                      i_is_load,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic [REG_ADDR_WIDTH-1:0] i_exmem_rd_addr,
    input  logic                      i_exmem_rd_we,
    input  logic [DATA_WIDTH-1:0]     i_exmem_result,
    input  logic [REG_ADDR_WIDTH-1:0] i_memwb_rd_addr,
    input  logic                      i_memwb_rd_we,
    input  logic [DATA_WIDTH-1:0]     i_memwb_result,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_elemA,
    output logic [DATA_WIDTH-1:0]     o_elemB,
    output alu_op_e                   o_op,
    output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
    output logic                      o_rd_we,
    output logic                      o_is_load,
    output logic                      o_load_use_stall
);

    localparam id_ex_t RESET_VAL = '{op: ADD_OP, default: '0};

    id_ex_t                  id_ex_q;
    id_ex_t                  id_ex_d;
    logic                    load_use_hit;
    logic [DATA_WIDTH-1:0]   fwd_a;
    logic [DATA_WIDTH-1:0]   fwd_b;
    fwd_sel_e                rs1_sel;
    fwd_sel_e                rs2_sel;

    // Held load whose result the decoding instruction needs next cycle.
    always_comb begin
        load_use_hit = id_ex_q.valid && id_ex_q.is_load && id_ex_q.rd_we &&
                       (id_ex_q.rd_addr != '0) && i_valid &&
                       ((i_rs1_addr == id_ex_q.rd_addr) ||
                        (!i_use_imm && (i_rs2_addr == id_ex_q.rd_addr)));
        // A flushed consumer is going away, so decode need not hold it.
        o_load_use_stall = load_use_hit && !i_flush;
    end

    // Next-state: flush > stall > load-use bubble > capture (reset handled in the flop).
    always_comb begin
        id_ex_d = id_ex_q;
        if (i_flush) begin
            id_ex_d.valid   = 1'b0;
            id_ex_d.rd_we   = 1'b0;
            id_ex_d.is_load = 1'b0;
        end else if (i_stall) begin
            id_ex_d = id_ex_q;
        end else if (load_use_hit) begin
            id_ex_d.valid   = 1'b0;
            id_ex_d.rd_we   = 1'b0;
            id_ex_d.is_load = 1'b0;
        end else begin
            id_ex_d = '{valid:    i_valid,
                        op:       i_op,
                        rs1_addr: i_rs1_addr,
                        rs2_addr: i_rs2_addr,
                        rs1_data: i_rs1_data,
                        rs2_data: i_rs2_data,
                        imm:      i_imm,
                        use_imm:  i_use_imm,
                        rd_addr:  i_rd_addr,
                        rd_we:    i_rd_we,
                        is_load:  i_is_load};
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_ex_q <= RESET_VAL;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    fwd_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .i_rs_addr       (id_ex_q.rs1_addr),
        .i_rf_data       (id_ex_q.rs1_data),
        .i_exmem_rd_addr (i_exmem_rd_addr),
        .i_exmem_rd_we   (i_exmem_rd_we),
        .i_exmem_result  (i_exmem_result),
        .i_memwb_rd_addr (i_memwb_rd_addr),
        .i_memwb_rd_we   (i_memwb_rd_we),
        .i_memwb_result  (i_memwb_result),
        .o_value         (fwd_a),
        .o_sel           (rs1_sel)
    );

    fwd_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .i_rs_addr       (id_ex_q.rs2_addr),
        .i_rf_data       (id_ex_q.rs2_data),
        .i_exmem_rd_addr (i_exmem_rd_addr),
        .i_exmem_rd_we   (i_exmem_rd_we),
        .i_exmem_result  (i_exmem_result),
        .i_memwb_rd_addr (i_memwb_rd_addr),
        .i_memwb_rd_we   (i_memwb_rd_we),
        .i_memwb_result  (i_memwb_result),
        .o_value         (fwd_b),
        .o_sel           (rs2_sel)
    );

    assign o_valid   = id_ex_q.valid;
    assign o_op      = id_ex_q.op;
    assign o_rd_addr = id_ex_q.rd_addr;
    assign o_rd_we   = id_ex_q.rd_we;
    assign o_is_load = id_ex_q.is_load;
    assign o_elemA   = fwd_a;
    assign o_elemB   = id_ex_q.use_imm ? id_ex_q.imm : fwd_b;

    // x0 must never pick up a bypassed value.
    a_x0_rs1_not_forwarded: assert property (@(posedge i_clk) disable iff (i_rst)
        (id_ex_q.rs1_addr != '0) || (rs1_sel == FWD_NONE));
    a_x0_rs2_not_forwarded: assert property (@(posedge i_clk) disable iff (i_rst)
        (id_ex_q.rs2_addr != '0) || (rs2_sel == FWD_NONE));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a reference model.
// Latency: model tracks the one-cycle register and combinational forwarding.
// Stall/flush/reset driven directly; no backpressure handshakes to honour.
module tb_id_ex_stage;
    import alu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_use_imm, i_rd_we, i_is_load, i_stall, i_flush;
    alu_op_e     i_op;
    logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr, i_exmem_rd_addr, i_memwb_rd_addr;
    logic [31:0] i_rs1_data, i_rs2_data, i_imm, i_exmem_result, i_memwb_result;
    logic        i_exmem_rd_we, i_memwb_rd_we;
    logic        o_valid, o_rd_we, o_is_load, o_load_use_stall;
    logic [31:0] o_elemA, o_elemB;
    alu_op_e     o_op;
    logic [4:0]  o_rd_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model of the instruction held in the stage.
    logic        m_valid, m_use_imm, m_we, m_ld;
    alu_op_e     m_op;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_d1, m_d2, m_imm;

    always #5 i_clk = ~i_clk;

    id_ex_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_op(i_op),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_imm(i_imm), .i_use_imm(i_use_imm), .i_rd_addr(i_rd_addr),
        .i_rd_we(i_rd_we), .i_is_load(i_is_load), .i_stall(i_stall), .i_flush(i_flush),
        .i_exmem_rd_addr(i_exmem_rd_addr), .i_exmem_rd_we(i_exmem_rd_we),
        .i_exmem_result(i_exmem_result), .i_memwb_rd_addr(i_memwb_rd_addr),
        .i_memwb_rd_we(i_memwb_rd_we), .i_memwb_result(i_memwb_result),
        .o_valid(o_valid), .o_elemA(o_elemA), .o_elemB(o_elemB), .o_op(o_op),
        .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we), .o_is_load(o_is_load),
        .o_load_use_stall(o_load_use_stall)
    );

    // Value a source register should read given the current writeback candidates.
    function automatic logic [31:0] exp_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (i_exmem_rd_we && i_exmem_rd_addr == a) return i_exmem_result;
        if (i_memwb_rd_we && i_memwb_rd_addr == a) return i_memwb_result;
        return rf;
    endfunction

    function automatic logic [31:0] exp_a();
        return exp_fwd(m_rs1, m_d1);
    endfunction

    function automatic logic [31:0] exp_b();
        return m_use_imm ? m_imm : exp_fwd(m_rs2, m_d2);
    endfunction

    function automatic logic exp_hazard();
        return m_valid && m_ld && m_we && (m_rd != 5'd0) && i_valid &&
               ((i_rs1_addr == m_rd) || (!i_use_imm && i_rs2_addr == m_rd));
    endfunction

    function automatic logic exp_stall();
        return exp_hazard() && !i_flush;
    endfunction

    task automatic clear_inputs();
        i_rst = 0; i_valid = 0; i_op = ADD_OP; i_rs1_addr = 0; i_rs2_addr = 0;
        i_rs1_data = 0; i_rs2_data = 0; i_imm = 0; i_use_imm = 0; i_rd_addr = 0;
        i_rd_we = 0; i_is_load = 0; i_stall = 0; i_flush = 0;
        i_exmem_rd_addr = 0; i_exmem_rd_we = 0; i_exmem_result = 0;
        i_memwb_rd_addr = 0; i_memwb_rd_we = 0; i_memwb_result = 0;
    endtask

    // One clock edge; the model applies reset > flush > stall > load-use > capture.
    task automatic tick();
        logic hz;
        @(posedge i_clk);
        hz = exp_hazard();
        if (i_rst) begin
            m_valid = 0; m_we = 0; m_ld = 0; m_op = ADD_OP; m_rs1 = 0; m_rs2 = 0;
            m_d1 = 0; m_d2 = 0; m_imm = 0; m_use_imm = 0; m_rd = 0;
        end else if (i_flush || (!i_stall && hz)) begin
            m_valid = 0; m_we = 0; m_ld = 0;
        end else if (!i_stall) begin
            m_valid = i_valid; m_op = i_op; m_rs1 = i_rs1_addr; m_rs2 = i_rs2_addr;
            m_d1 = i_rs1_data; m_d2 = i_rs2_data; m_imm = i_imm; m_use_imm = i_use_imm;
            m_rd = i_rd_addr; m_we = i_rd_we; m_ld = i_is_load;
        end
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst = 1;
        tick(); tick();
        i_rst = 0; #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        n_cmp++; if (o_rd_we !== 1'b0) begin n_fail++; $display("FAIL reset_rd_we got %b exp 0", o_rd_we); end
        n_cmp++; if (o_is_load !== 1'b0) begin n_fail++; $display("FAIL reset_is_load got %b exp 0", o_is_load); end
        n_cmp++; if (o_op !== ADD_OP) begin n_fail++; $display("FAIL reset_op got %0d exp %0d", o_op, ADD_OP); end
        n_cmp++; if (o_rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr got %0d exp 0", o_rd_addr); end
        n_cmp++; if (o_load_use_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", o_load_use_stall); end
    endtask

    task automatic test_capture();
        clear_inputs();
        i_valid = 1; i_op = SUB_OP; i_rs1_addr = 3; i_rs1_data = 10;
        i_rs2_addr = 4; i_rs2_data = 5; i_rd_addr = 6; i_rd_we = 1;
        tick();
        clear_inputs(); #1;
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid got %b exp 1", o_valid); end
        n_cmp++; if (o_op !== SUB_OP) begin n_fail++; $display("FAIL cap_op got %0d exp %0d", o_op, SUB_OP); end
        n_cmp++; if (o_elemA !== 32'd10) begin n_fail++; $display("FAIL cap_A got %0d exp 10", o_elemA); end
        n_cmp++; if (o_elemB !== 32'd5) begin n_fail++; $display("FAIL cap_B got %0d exp 5", o_elemB); end
        n_cmp++; if (o_rd_addr !== 5'd6) begin n_fail++; $display("FAIL cap_rd got %0d exp 6", o_rd_addr); end
    endtask

    task automatic test_forward();
        clear_inputs();
        i_valid = 1; i_rs1_addr = 7; i_rs1_data = 32'h11; i_rs2_addr = 0; i_rs2_data = 32'h99;
        tick();
        clear_inputs();
        i_exmem_rd_addr = 7; i_exmem_rd_we = 1; i_exmem_result = 32'hAA;
        i_memwb_rd_addr = 7; i_memwb_rd_we = 1; i_memwb_result = 32'hBB;
        #1;
        n_cmp++; if (o_elemA !== 32'hAA) begin n_fail++; $display("FAIL fwd_exmem got %h exp aa", o_elemA); end
        n_cmp++; if (o_elemB !== 32'h0) begin n_fail++; $display("FAIL fwd_x0_rfdata got %h exp 0", o_elemB); end
        i_exmem_rd_we = 0; #1;
        n_cmp++; if (o_elemA !== 32'hBB) begin n_fail++; $display("FAIL fwd_memwb got %h exp bb", o_elemA); end
        i_memwb_rd_we = 0; #1;
        n_cmp++; if (o_elemA !== 32'h11) begin n_fail++; $display("FAIL fwd_none got %h exp 11", o_elemA); end
        // x0 source with both candidates claiming x0.
        i_valid = 1; i_rs1_addr = 0; i_rs1_data = 32'h55; i_rs2_addr = 2; i_rs2_data = 32'h3;
        i_exmem_rd_addr = 0; i_exmem_rd_we = 1; i_exmem_result = 32'hAA;
        i_memwb_rd_addr = 0; i_memwb_rd_we = 1; i_memwb_result = 32'hBB;
        tick();
        n_cmp++; if (o_elemA !== 32'h0) begin n_fail++; $display("FAIL fwd_x0 got %h exp 0", o_elemA); end
        i_memwb_rd_addr = 2; #1;
        n_cmp++; if (o_elemB !== 32'hBB) begin n_fail++; $display("FAIL fwd_rs2_memwb got %h exp bb", o_elemB); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        i_valid = 1; i_is_load = 1; i_rd_addr = 5; i_rd_we = 1; i_rs1_addr = 1;
        tick();
        clear_inputs();
        i_valid = 1; i_rs1_addr = 1; i_rs2_addr = 5; i_use_imm = 0; i_rd_addr = 9; i_rd_we = 1;
        #1;
        n_cmp++; if (o_load_use_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b exp 1", o_load_use_stall); end
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %b exp 0", o_valid); end
        n_cmp++; if (o_rd_we !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_we got %b exp 0", o_rd_we); end
        clear_inputs();
        i_valid = 1; i_is_load = 1; i_rd_addr = 5; i_rd_we = 1;
        tick();
        clear_inputs();
        i_valid = 1; i_use_imm = 1; i_rs1_addr = 2; i_rs2_addr = 5; i_imm = 32'h40;
        i_rd_addr = 8; i_rd_we = 1;
        #1;
        n_cmp++; if (o_load_use_stall !== 1'b0) begin n_fail++; $display("FAIL lu_imm_stall got %b exp 0", o_load_use_stall); end
        tick();
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL lu_imm_valid got %b exp 1", o_valid); end
        n_cmp++; if (o_elemB !== 32'h40) begin n_fail++; $display("FAIL lu_imm_B got %h exp 40", o_elemB); end
        n_cmp++; if (o_rd_addr !== 5'd8) begin n_fail++; $display("FAIL lu_imm_rd got %0d exp 8", o_rd_addr); end
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        i_valid = 1; i_op = XOR_OP; i_rs1_addr = 9; i_rs1_data = 32'h20;
        i_rs2_addr = 10; i_rs2_data = 32'h30; i_rd_addr = 11; i_rd_we = 1;
        tick();
        i_stall = 1; i_op = OR_OP; i_rs1_addr = 1; i_rs1_data = 1; i_rd_addr = 12;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (o_valid !== 1'b1 || o_op !== XOR_OP || o_rd_addr !== 5'd11 || o_elemA !== 32'h20)
                begin n_fail++; $display("FAIL stall_hold[%0d] got v=%b op=%0d rd=%0d A=%h exp v=1 op=%0d rd=11 A=20",
                                         c, o_valid, o_op, o_rd_addr, o_elemA, XOR_OP); end
        end
        i_exmem_rd_addr = 9; i_exmem_rd_we = 1; i_exmem_result = 32'hDEAD; #1;
        n_cmp++; if (o_elemA !== 32'hDEAD) begin n_fail++; $display("FAIL stall_fwd_A got %h exp dead", o_elemA); end
        n_cmp++; if (o_elemB !== 32'h30) begin n_fail++; $display("FAIL stall_B got %h exp 30", o_elemB); end
        i_flush = 1;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall_valid got %b exp 0", o_valid); end
        n_cmp++; if (o_rd_we !== 1'b0) begin n_fail++; $display("FAIL flush_stall_we got %b exp 0", o_rd_we); end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        i_valid = 1; i_is_load = 1; i_rd_addr = 3; i_rd_we = 1;
        tick();
        clear_inputs();
        i_stall = 1; i_valid = 1; i_rs1_addr = 3; #1;
        n_cmp++; if (o_load_use_stall !== 1'b1) begin n_fail++; $display("FAIL rm_stall_pre got %b exp 1", o_load_use_stall); end
        tick();
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rm_held got %b exp 1", o_valid); end
        i_rst = 1;
        tick();
        i_rst = 0; #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b exp 0", o_valid); end
        n_cmp++; if (o_load_use_stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall got %b exp 0", o_load_use_stall); end
    endtask

    task automatic test_random();
        clear_inputs();
        i_rst = 1; tick(); i_rst = 0;
        for (int n = 0; n < 400; n++) begin
            i_rst      = ($urandom_range(0, 49) == 0);
            i_flush    = ($urandom_range(0, 9) == 0);
            i_stall    = ($urandom_range(0, 4) == 0);
            i_valid    = ($urandom_range(0, 3) != 0);
            i_op       = alu_op_e'(4'($urandom_range(0, 9)));
            i_rs1_addr = 5'($urandom_range(0, 3));
            i_rs2_addr = 5'($urandom_range(0, 3));
            i_rd_addr  = 5'($urandom_range(0, 3));
            i_rs1_data = $urandom; i_rs2_data = $urandom; i_imm = $urandom;
            i_use_imm  = 1'($urandom_range(0, 1));
            i_rd_we    = 1'($urandom_range(0, 1));
            i_is_load  = ($urandom_range(0, 2) == 0);
            i_exmem_rd_addr = 5'($urandom_range(0, 3));
            i_exmem_rd_we   = 1'($urandom_range(0, 1));
            i_exmem_result  = $urandom;
            i_memwb_rd_addr = 5'($urandom_range(0, 3));
            i_memwb_rd_we   = 1'($urandom_range(0, 1));
            i_memwb_result  = $urandom;
            #1;
            n_cmp++; if ({o_valid, o_rd_we, o_is_load} !== {m_valid, m_we, m_ld})
                begin n_fail++; $display("FAIL rnd_ctrl[%0d] got %b%b%b exp %b%b%b", n,
                                         o_valid, o_rd_we, o_is_load, m_valid, m_we, m_ld); end
            n_cmp++; if (o_load_use_stall !== exp_stall())
                begin n_fail++; $display("FAIL rnd_stall[%0d] got %b exp %b", n, o_load_use_stall, exp_stall()); end
            if (m_valid) begin
                n_cmp++; if (o_op !== m_op || o_rd_addr !== m_rd)
                    begin n_fail++; $display("FAIL rnd_op_rd[%0d] got %0d/%0d exp %0d/%0d", n, o_op, o_rd_addr, m_op, m_rd); end
                n_cmp++; if (o_elemA !== exp_a())
                    begin n_fail++; $display("FAIL rnd_A[%0d] got %h exp %h", n, o_elemA, exp_a()); end
                n_cmp++; if (o_elemB !== exp_b())
                    begin n_fail++; $display("FAIL rnd_B[%0d] got %h exp %h", n, o_elemB, exp_b()); end
            end
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_capture();
        test_forward();
        test_load_use();
        test_stall_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
